seq_det_1011: RTL and testbench

- Serial bit-stream pattern detector for the sequence 1-0-1-1, with the oldest bit first.
- Implemented as a 4-state Mealy FSM that samples one input bit per rising clock edge.
- det_o is a combinational pulse that asserts during the cycle in which the final '1' of the pattern is present on seq_in.
- Sits on a serial data path as a framing/marker detector.
- Provides a saturating detection counter for status reporting.

---
 rtl/seq_det_1011.sv | 89 ++++++++
 tb/tb_seq_det_1011.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_det_1011.sv
// Serial 1-0-1-1 pattern detector (oldest bit first): 4-state Mealy FSM with a
// combinational detect pulse and a saturating detection counter.
module seq_det_1011 #(
  parameter int unsigned OVERLAP = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seq_in,
  output logic             det_o,
  output logic [CNT_W-1:0] det_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S1   = 2'b01,
    S10  = 2'b10,
    S101 = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           w_state_nxt;
  logic             w_det;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] r_det_count;

  // State register; reset discards any partial match.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= w_state_nxt;
    end
  end

  // Next-state and Mealy detect decode.
  always_comb begin
    w_state_nxt = state;
    w_det       = 1'b0;
    case (state)
      IDLE: begin
        if (seq_in) w_state_nxt = S1;
        else        w_state_nxt = IDLE;
      end
      S1: begin
        if (seq_in) w_state_nxt = S1;
        else        w_state_nxt = S10;
      end
      S10: begin
        if (seq_in) w_state_nxt = S101;
        else        w_state_nxt = IDLE;
      end
      S101: begin
        if (seq_in) begin
          // The final 1 can serve as the first bit of the next match only in overlap mode.
          w_det = 1'b1;
          if (OVERLAP != 0) w_state_nxt = S1;
          else              w_state_nxt = IDLE;
        end else begin
          w_state_nxt = S10;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_det       = 1'b0;
      end
    endcase
  end

  assign w_cnt_sat = &r_det_count;

  // Detection counter, sticks at all-ones until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_det_count <= CNT_ZERO;
    end else if (w_det && !w_cnt_sat) begin
      r_det_count <= r_det_count + CNT_ONE;
    end else begin
      r_det_count <= r_det_count;
    end
  end

  assign det_o     = w_det;
  assign det_count = r_det_count;

endmodule

// File: tb/tb_seq_det_1011.sv
// Directed bench for seq_det_1011: overlap, non-overlap and saturating-counter
// instances, with expected results queued at drive time and checked on output.
module tb_seq_det_1011;

  logic       clock = 1'b0;
  logic       reset;
  logic       seq_a, seq_b, seq_c;
  logic       det_a, det_b, det_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] st;
    logic       dt;
    int         cnt;
  } exp_t;

  exp_t q[$];

  always #5 clock = ~clock;

  seq_det_1011 #(.OVERLAP(1), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .seq_in(seq_a), .det_o(det_a), .det_count(cnt_a));
  seq_det_1011 #(.OVERLAP(0), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .seq_in(seq_b), .det_o(det_b), .det_count(cnt_b));
  seq_det_1011 #(.OVERLAP(1), .CNT_W(2)) dut_c (
    .clock(clock), .reset(reset), .seq_in(seq_c), .det_o(det_c), .det_count(cnt_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit on the falling edge into instance sel; check state/det mid-cycle
  // and the counter just after the following rising edge.
  task automatic step(input int sel, input string tag, input logic b,
                      input logic [1:0] st, input logic dt, input int cnt);
    exp_t       e;
    logic [1:0] o_st;
    logic       o_dt;
    int         o_cnt;
    q.push_back('{st: st, dt: dt, cnt: cnt});
    @(negedge clock);
    case (sel)
      0:       seq_a = b;
      1:       seq_b = b;
      default: seq_c = b;
    endcase
    #1;
    e = q.pop_front();
    case (sel)
      0:       begin o_st = dut_a.state; o_dt = det_a; end
      1:       begin o_st = dut_b.state; o_dt = det_b; end
      default: begin o_st = dut_c.state; o_dt = det_c; end
    endcase
    chk({tag, " state"}, 32'(o_st), 32'(e.st));
    chk({tag, " det"}, 32'(o_dt), 32'(e.dt));
    if (o_st == 2'b11 && e.dt && o_dt === 1'b1) $display("correct output at state 11");
    @(posedge clock);
    #1;
    case (sel)
      0:       o_cnt = int'(cnt_a);
      1:       o_cnt = int'(cnt_b);
      default: o_cnt = int'(cnt_c);
    endcase
    chk({tag, " count"}, 32'(o_cnt), 32'(e.cnt));
  endtask

  // Async reset on a falling edge; everything must clear before the next rising edge.
  task automatic do_reset(input string tag);
    @(negedge clock);
    seq_a = 1'b0; seq_b = 1'b0; seq_c = 1'b0;
    reset = 1'b0;
    #1;
    chk({tag, " a state"}, 32'(dut_a.state), 32'h0);
    chk({tag, " a count"}, 32'(cnt_a), 32'h0);
    chk({tag, " b count"}, 32'(cnt_b), 32'h0);
    chk({tag, " c count"}, 32'(cnt_c), 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    seq_a = 1'b0; seq_b = 1'b0; seq_c = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst a state", 32'(dut_a.state), 32'h0);
    chk("rst b state", 32'(dut_b.state), 32'h0);
    chk("rst c state", 32'(dut_c.state), 32'h0);
    chk("rst a det", 32'(det_a), 32'h0);
    chk("rst a count", 32'(cnt_a), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 3; i++) step(0, "idle0", 1'b0, 2'b00, 1'b0, 0);
    chk("idle0 b state", 32'(dut_b.state), 32'h0);
    chk("idle0 c count", 32'(cnt_c), 32'h0);

    // 0,1,0,1,0,1,1 : one detection on the last bit
    step(0, "s1", 1'b0, 2'b00, 1'b0, 0);
    step(0, "s1", 1'b1, 2'b00, 1'b0, 0);
    step(0, "s1", 1'b0, 2'b01, 1'b0, 0);
    step(0, "s1", 1'b1, 2'b10, 1'b0, 0);
    step(0, "s1", 1'b0, 2'b11, 1'b0, 0);
    step(0, "s1", 1'b1, 2'b10, 1'b0, 0);
    step(0, "s1", 1'b1, 2'b11, 1'b1, 1);

    // partial match then reset mid-stream, then a fresh 1011
    step(0, "mid", 1'b1, 2'b01, 1'b0, 1);
    step(0, "mid", 1'b0, 2'b01, 1'b0, 1);
    do_reset("midrst");
    step(0, "post", 1'b1, 2'b00, 1'b0, 0);
    step(0, "post", 1'b0, 2'b01, 1'b0, 0);
    step(0, "post", 1'b1, 2'b10, 1'b0, 0);
    step(0, "post", 1'b1, 2'b11, 1'b1, 1);

    // overlap: 1,0,1,1,0,1,1 -> bits 4 and 7
    do_reset("ovrst1");
    step(0, "ov1", 1'b1, 2'b00, 1'b0, 0);
    step(0, "ov1", 1'b0, 2'b01, 1'b0, 0);
    step(0, "ov1", 1'b1, 2'b10, 1'b0, 0);
    step(0, "ov1", 1'b1, 2'b11, 1'b1, 1);
    step(0, "ov1", 1'b0, 2'b01, 1'b0, 1);
    step(0, "ov1", 1'b1, 2'b10, 1'b0, 1);
    step(0, "ov1", 1'b1, 2'b11, 1'b1, 2);

    // overlap: 1,0,1,1,1,0,1,1 -> bits 4 and 8
    do_reset("ovrst2");
    step(0, "ov2", 1'b1, 2'b00, 1'b0, 0);
    step(0, "ov2", 1'b0, 2'b01, 1'b0, 0);
    step(0, "ov2", 1'b1, 2'b10, 1'b0, 0);
    step(0, "ov2", 1'b1, 2'b11, 1'b1, 1);
    step(0, "ov2", 1'b1, 2'b01, 1'b0, 1);
    step(0, "ov2", 1'b0, 2'b01, 1'b0, 1);
    step(0, "ov2", 1'b1, 2'b10, 1'b0, 1);
    step(0, "ov2", 1'b1, 2'b11, 1'b1, 2);

    // non-overlap: match returns to IDLE, so 1,0,1,1,1,0,1,1 -> bits 4 and 8
    do_reset("nvrst");
    step(1, "nov", 1'b1, 2'b00, 1'b0, 0);
    step(1, "nov", 1'b0, 2'b01, 1'b0, 0);
    step(1, "nov", 1'b1, 2'b10, 1'b0, 0);
    step(1, "nov", 1'b1, 2'b11, 1'b1, 1);
    step(1, "nov", 1'b1, 2'b00, 1'b0, 1);
    step(1, "nov", 1'b0, 2'b01, 1'b0, 1);
    step(1, "nov", 1'b1, 2'b10, 1'b0, 1);
    step(1, "nov", 1'b1, 2'b11, 1'b1, 2);
    step(1, "nov11", 1'b1, 2'b00, 1'b0, 2);
    step(1, "nov11", 1'b1, 2'b01, 1'b0, 2);
    step(1, "nov11", 1'b0, 2'b01, 1'b0, 2);

    // saturation: 5 back-to-back 1011 into a 2-bit counter
    do_reset("satrst");
    for (int p = 0; p < 5; p++) begin
      step(2, "sat", 1'b1, (p == 0) ? 2'b00 : 2'b01, 1'b0, (p > 3) ? 3 : p);
      step(2, "sat", 1'b0, 2'b01, 1'b0, (p > 3) ? 3 : p);
      step(2, "sat", 1'b1, 2'b10, 1'b0, (p > 3) ? 3 : p);
      step(2, "sat", 1'b1, 2'b11, 1'b1, (p > 2) ? 3 : p + 1);
    end
    step(2, "sathold", 1'b0, 2'b01, 1'b0, 3);
    step(2, "sathold", 1'b1, 2'b10, 1'b0, 3);

    // in S101 with seq_in=1, reset must force det_o low and clear the count at once
    @(negedge clock);
    seq_c = 1'b1;
    reset = 1'b0;
    #1;
    chk("satrst det", 32'(det_c), 32'h0);
    chk("satrst state", 32'(dut_c.state), 32'h0);
    chk("satrst count", 32'(cnt_c), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    seq_c = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
